poly_small_trim_decode: RTL and testbench
=========================================

POLY_SMALL_TRIM_DECODE -- requirements
Module: poly_small_trim_decode

Interface
REQ-001 Parameter logn, default 9: log2 of polynomial degree n = 2^logn; legal values are 9 and 10.
REQ-002 Derived constant enc_bit: 6 when logn==9, 5 when logn==10; this is the per-coefficient encoded width.
REQ-003 Derived constant f_bit: 7 when logn==9, 6 when logn==10; this is the output coefficient width, matching the sqnorm consumer.
REQ-004 clk  in  1  Single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  Asynchronous, active-low reset.
REQ-006 ena  in  1  Start request; sampled only in IDLE.
REQ-007 b_valid  in  1  Input byte valid.
REQ-008 b  in  8  Encoded byte stream, MSB-first bit order.
REQ-009 b_ready  out  1  Block can accept a byte this cycle.
REQ-010 f_valid  out  1  Decoded coefficient valid; one-cycle pulse per coefficient.
REQ-011 f  out  f_bit (signed)  Decoded coefficient, sign-extended.
REQ-012 done  out  1  One-cycle pulse when decoding ends, whether it completes or aborts.
REQ-013 err  out  1  Forbidden-code flag; valid in the done cycle and held until the next start.

Function
REQ-014 FSM states are IDLE, RUN and DONE.
- IDLE to RUN when ena==1.
- RUN to DONE after n coefficients have been emitted, or on an error.
- DONE to IDLE on the next cycle.
REQ-015 On entry to RUN, the bit accumulator, the bit count acc_len and the coefficient counter cnt all SHALL clear, and err SHALL clear.
REQ-016 Accumulator width SHALL be at least 8+enc_bit-1 bits; acc_len SHALL be 4 bits.
REQ-017 b_ready SHALL be 1 only when the state is RUN and acc_len < enc_bit; a byte is accepted when b_valid && b_ready.
REQ-018 On byte acceptance: acc = (acc<<8)|b and acc_len += 8.
REQ-019 In RUN with acc_len >= enc_bit, in that cycle:
- extract w = acc[acc_len-1 -: enc_bit];
- set acc_len -= enc_bit;
- sign-extend w to f_bit.
REQ-020 The extracted coefficient SHALL be registered: f_valid=1 and f=value on the following cycle. This is a one-cycle latency from extraction; at most one coefficient is emitted per cycle, and there is no output backpressure.
REQ-021 Byte acceptance and extraction are mutually exclusive in any cycle.
REQ-022 cnt increments on each emitted coefficient. When cnt reaches n-1 and that coefficient is emitted, the block SHALL enter DONE and done=1 for one cycle, coincident with the last f_valid.
REQ-023 The stream length SHALL be n*enc_bit/8 bytes (384 or 640), so acc_len==0 at completion. If acc_len!=0 or residual bits are nonzero at completion, err SHALL be set.
REQ-024 ena asserted in RUN or DONE SHALL be ignored.
REQ-025 Bytes presented while b_ready==0 SHALL NOT be consumed.
REQ-026 Idle cycles on b_valid SHALL stall decoding without losing state.

Reset
REQ-027 While rst_n==0, the block SHALL hold:
- state=IDLE;
- b_ready=0, f_valid=0, f=0, done=0, err=0;
- acc=0, acc_len=0, cnt=0.
REQ-028 Reset asserted mid-decode SHALL abort immediately, with no done pulse; a new ena is required to restart.

Configuration
REQ-029 Macro POLY_TRIM_ERR_CHECK_EN.
- Defined: a code equal to -2^(enc_bit-1) (e.g. 100000b) SHALL NOT be emitted. The block SHALL set err=1, pulse done next cycle, and enter DONE; remaining bytes are not consumed.
- Undefined: that code SHALL be emitted as -2^(enc_bit-1), and err SHALL be driven only by REQ-023.

Structure
REQ-030 A shared package poly_small_pkg SHALL hold:
- functions enc_bit(logn), f_bit(logn) and n(logn);
- the FSM state typedef;
- a constant for the byte width (8).
REQ-031 One sub-module, poly_trim_bitbuf, SHALL contain the accumulator, acc_len, byte append, extract and sign-extend. The top level SHALL hold the FSM, cnt, error logic and output registers.

Verification
REQ-032 Reset: with rst_n low mid-RUN, all outputs are 0 and state is IDLE; after release, no f_valid appears until ena.
REQ-033 logn=9, bytes 0x04,0x10,0x41 then zeros to 384 bytes: first four f=+1, remaining 508 f=0, done with err=0. A chained sqnorm gives s=4.
REQ-034 logn=9, 384 bytes of 0xFF: 512 pulses with f=-1, done pulse coincident with the 512th, err=0. Chained s=512.
REQ-035 logn=9, first byte 0x80:
- with macro defined: no f_valid, err=1, done pulse, b_ready=0 thereafter;
- with macro undefined: first f=-32.
REQ-036 logn=10, 640 bytes of 0x00 with random b_valid gaps (1-5 cycles): exactly 1024 f_valid with f=0; ena pulsed mid-RUN is ignored.
REQ-037 Back-to-back decodes with ena in the cycle after done: the second run starts cleanly with err cleared and counts correct.

Source files
------------

// File: rtl/poly_small_pkg.sv
// rtl/poly_small_pkg.sv - shared constants, sizing functions and FSM state type for the trim decoder
package poly_small_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int enc_bit(input int logn);
        return (logn == 10) ? 5 : 6;
    endfunction

    function automatic int f_bit(input int logn);
        return (logn == 10) ? 6 : 7;
    endfunction

    function automatic int n(input int logn);
        return 1 << logn;
    endfunction

endpackage

// File: rtl/poly_trim_bitbuf.sv
// rtl/poly_trim_bitbuf.sv - MSB-first bit accumulator: byte append, fixed-width extract, sign extension
module poly_trim_bitbuf
    import poly_small_pkg::*;
#(
    parameter int ENC   = 6,
    parameter int FB    = 7,
    parameter int ACC_W = BYTE_W + ENC - 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 push,
    input  logic [BYTE_W-1:0]    byte_in,
    input  logic                 pop,
    output logic [3:0]           acc_len,
    output logic signed [FB-1:0] code_sx,
    output logic                 rem_nz
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [3:0]       len_q, len_d;
    logic [3:0]       new_len;
    logic [ACC_W-1:0] shifted;
    logic [ACC_W-1:0] keep_mask;
    logic [ENC-1:0]   code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            len_q <= '0;
        end else begin
            acc_q <= acc_d;
            len_q <= len_d;
        end
    end

    always_comb begin
        new_len   = len_q - 4'(ENC);
        shifted   = acc_q >> new_len;
        code      = shifted[ENC-1:0];
        code_sx   = {{(FB-ENC){code[ENC-1]}}, code};
        // Bits below the extracted field are the only live data after a pop.
        keep_mask = (ACC_W'(1) << new_len) - ACC_W'(1);
        rem_nz    = (new_len != 4'd0) || ((acc_q & keep_mask) != '0);
        acc_d     = acc_q;
        len_d     = len_q;
        if (clr) begin
            acc_d = '0;
            len_d = '0;
        end else if (push) begin
            acc_d = {acc_q[ACC_W-BYTE_W-1:0], byte_in};
            len_d = len_q + 4'(BYTE_W);
        end else if (pop) begin
            acc_d = acc_q & keep_mask;
            len_d = new_len;
        end
    end

    assign acc_len = len_q;

endmodule

// File: rtl/poly_small_trim_decode.sv
// rtl/poly_small_trim_decode.sv - small-coefficient trim decoder; optional forbidden-code check under POLY_TRIM_ERR_CHECK_EN
module poly_small_trim_decode
    import poly_small_pkg::*;
#(
    parameter int logn = 9
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic                          b_valid,
    input  logic [7:0]                    b,
    output logic                          b_ready,
    output logic                          f_valid,
    output logic signed [f_bit(logn)-1:0] f,
    output logic                          done,
    output logic                          err
);

    localparam int ENC = enc_bit(logn);
    localparam int FB  = f_bit(logn);
    localparam int NN  = n(logn);

    state_t                state_q, state_d;
    logic [logn-1:0]       cnt_q, cnt_d;
    logic signed [FB-1:0]  f_q, f_d;
    logic                  f_valid_q, f_valid_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [3:0]            acc_len;
    logic signed [FB-1:0]  code_sx;
    logic                  rem_nz;
    logic                  start, push, pop, last, bad;

    poly_trim_bitbuf #(.ENC(ENC), .FB(FB)) u_bitbuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start),
        .push    (push),
        .byte_in (b),
        .pop     (pop),
        .acc_len (acc_len),
        .code_sx (code_sx),
        .rem_nz  (rem_nz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            f_q       <= '0;
            f_valid_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            f_q       <= f_d;
            f_valid_q <= f_valid_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        start   = (state_q == ST_IDLE) && ena;
        b_ready = (state_q == ST_RUN) && (acc_len < 4'(ENC));
        pop     = (state_q == ST_RUN) && (acc_len >= 4'(ENC));
        push    = b_valid && b_ready;
        last    = pop && (cnt_q == logn'(NN - 1));
`ifdef POLY_TRIM_ERR_CHECK_EN
        bad     = pop && (code_sx == FB'(-(2 ** (ENC - 1))));
`else
        bad     = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ena) state_d = ST_RUN;
            ST_RUN:  if (bad || last) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // done is registered alongside the final f so both rise in the same cycle.
    always_comb begin
        cnt_d     = cnt_q;
        f_d       = f_q;
        f_valid_d = 1'b0;
        done_d    = 1'b0;
        err_d     = err_q;
        if (start) begin
            cnt_d = '0;
            err_d = 1'b0;
        end
        if (bad) begin
            err_d  = 1'b1;
            done_d = 1'b1;
        end else if (pop) begin
            f_valid_d = 1'b1;
            f_d       = code_sx;
            cnt_d     = cnt_q + 1'b1;
            if (last) begin
                done_d = 1'b1;
                if (rem_nz) err_d = 1'b1;
            end
        end
    end

    assign f_valid = f_valid_q;
    assign f       = f_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_poly_small_trim_decode.sv
// tb/tb_poly_small_trim_decode.sv - scoreboard bench for logn=9 and logn=10 trim decoders
module tb_poly_small_trim_decode;

`ifdef POLY_TRIM_ERR_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena9 = 1'b0, ena10 = 1'b0;
    logic bv = 1'b0;
    logic [7:0] b = 8'h00;
    logic sel = 1'b0;

    logic rdy9, fv9, done9, err9;
    logic signed [6:0] f9;
    logic rdy10, fv10, done10, err10;
    logic signed [5:0] f10;

    always #5 clk = ~clk;

    poly_small_trim_decode #(.logn(9)) dut9 (
        .clk(clk), .rst_n(rst_n), .ena(ena9), .b_valid(bv && !sel), .b(b),
        .b_ready(rdy9), .f_valid(fv9), .f(f9), .done(done9), .err(err9)
    );

    poly_small_trim_decode #(.logn(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .ena(ena10), .b_valid(bv && sel), .b(b),
        .b_ready(rdy10), .f_valid(fv10), .f(f10), .done(done10), .err(err10)
    );

    logic cur_ready, cur_fv, cur_done, cur_err;
    int   cur_f;
    assign cur_ready = sel ? rdy10 : rdy9;
    assign cur_fv    = sel ? fv10 : fv9;
    assign cur_done  = sel ? done10 : done9;
    assign cur_err   = sel ? err10 : err9;
    assign cur_f     = sel ? int'(f10) : int'(f9);

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Independent bit-level reference model and scoreboard.
    int expq[$];
    bit mbits[$];
    int menc, exp_total, exp_s;
    bit mstop, exp_err;
    int rx, s_acc;
    bit done_flag, err_at_done, fv_at_done;

    task automatic model_init(input bit s);
        mbits.delete();
        expq.delete();
        menc = s ? 5 : 6;
        exp_total = 0; exp_s = 0; mstop = 0; exp_err = 0;
        rx = 0; s_acc = 0; done_flag = 0; err_at_done = 0; fv_at_done = 0;
    endtask

    task automatic model_push(input logic [7:0] v);
        int val;
        for (int k = 7; k >= 0; k--) mbits.push_back(v[k]);
        while (!mstop && mbits.size() >= menc) begin
            val = 0;
            for (int k = 0; k < menc; k++) val = (val << 1) | int'(mbits.pop_front());
            if (val >= (1 << (menc - 1))) val -= (1 << menc);
            if (CHK_EN && val == -(1 << (menc - 1))) begin
                mstop = 1; exp_err = 1;
            end else begin
                expq.push_back(val);
                exp_total++;
                exp_s += val * val;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (cur_fv) begin
                rx++;
                s_acc += cur_f * cur_f;
                if (expq.size() == 0) chk("f_unexpected", 1, 0);
                else chk("f", cur_f, expq.pop_front());
            end
            if (cur_done) begin
                done_flag   = 1;
                err_at_done = cur_err;
                fv_at_done  = cur_fv;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_byte(input logic [7:0] v);
        int tmo = 0;
        b = v; bv = 1'b1;
        while (!cur_ready && tmo < 100) begin
            @(negedge clk);
            tmo++;
        end
        if (tmo >= 100) begin
            chk("ready_timeout", 0, 1);
            bv = 1'b0;
        end else begin
            @(posedge clk);
            model_push(v);
            @(negedge clk);
        end
    endtask

    function automatic logic [7:0] pat_byte(input int pat, input int i);
        case (pat)
            0: return (i == 0) ? 8'h04 : (i == 1) ? 8'h10 : (i == 2) ? 8'h41 : 8'h00;
            1: return 8'hFF;
            2: return (i == 0) ? 8'h80 : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    task automatic pulse_ena(input bit s);
        if (s) ena10 = 1'b1; else ena9 = 1'b1;
        @(negedge clk);
        ena9 = 1'b0; ena10 = 1'b0;
    endtask

    task automatic run_decode(input bit s, input int pat, input bit gaps);
        int nbytes, tmo;
        @(negedge clk);
        sel = s;
        model_init(s);
        pulse_ena(s);
        chk("err_cleared_at_start", cur_err, 0);
        nbytes = s ? 640 : 384;
        for (int i = 0; i < nbytes; i++) begin
            if (mstop) break;
            if (gaps && $urandom_range(0, 3) == 0) begin
                bv = 1'b0;
                repeat ($urandom_range(1, 5)) @(negedge clk);
            end
            if (gaps && i == 300) begin
                bv = 1'b0;
                pulse_ena(s);
            end
            send_byte(pat_byte(pat, i));
        end
        bv = 1'b0;
        tmo = 0;
        while (!done_flag && tmo < 100) begin
            @(negedge clk);
            #1;
            tmo++;
        end
        chk("done_seen", int'(done_flag), 1);
        chk("coeff_count", rx, exp_total);
        chk("err_at_done", int'(err_at_done), int'(exp_err));
        chk("fvalid_with_done", int'(fv_at_done), int'(!exp_err));
        chk("sqnorm", s_acc, exp_s);
        chk("queue_drained", expq.size(), 0);
        chk("ready_after_done", int'(cur_ready), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_init(0);
        repeat (3) @(negedge clk);
        chk("rst_ready9", int'(rdy9), 0);
        chk("rst_fvalid9", int'(fv9), 0);
        chk("rst_done10", int'(done10), 0);
        chk("rst_err10", int'(err10), 0);
        chk("rst_f9", int'(f9), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready9", int'(rdy9), 0);

        // Reset asserted in the middle of a decode.
        pulse_ena(0);
        for (int i = 0; i < 10; i++) send_byte(8'hFF);
        bv = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_fvalid", int'(fv9), 0);
        chk("midrst_done", int'(done9), 0);
        chk("midrst_err", int'(err9), 0);
        chk("midrst_ready", int'(rdy9), 0);
        chk("midrst_f", int'(f9), 0);
        chk("midrst_state", int'(dut9.state_q), 0);
        expq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("postrst_ready", int'(rdy9), 0);
        chk("postrst_no_done", int'(done_flag), 0);

        run_decode(0, 2, 0);
        run_decode(0, 0, 0);
        run_decode(0, 1, 0);
        run_decode(1, 3, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
